rca_add_scheduler: RTL

Shares one 4-bit ripple-carry nibble adder between two requesters and sequences it to perform 4·NIBBLES-bit additions, one nibble per clock, least significant nibble first. Arbitration between the requesters is round-robin. Results are returned with the winning requester's ID and a carry-out. The block sits between operand producers and any consumer that needs wide sums but can only afford a single 4-bit adder slice.

---
 rtl/rca_add_scheduler.sv | 100 ++++++++++
 1 files changed

// File: rtl/rca_add_scheduler.sv
// Round-robin scheduler sharing one 4-bit ripple-carry slice between two requesters;
// each W-bit add is sequenced one nibble per clock, least significant nibble first.
module rca_add_scheduler #(
    parameter int NIBBLES = 4,
    localparam int W = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         req1_ready,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_sum,
    output logic         res_cout,
    output logic         res_id,
    output logic         busy
);
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q;
    logic          last_grant_q;
    logic [W-1:0]  a_q, b_q, acc_q, sum_q;
    logic          carry_q, cout_q, id_q;
    logic [CW-1:0] cnt_q;

    logic          grant, any_valid;
    logic [4:0]    nib;
    logic [W-1:0]  acc_d;

    always_comb begin
        any_valid  = req0_valid | req1_valid;
        grant      = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
        req0_ready = ~rst && (state_q == IDLE) && any_valid && ~grant;
        req1_ready = ~rst && (state_q == IDLE) && any_valid &&  grant;
        nib        = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0000, carry_q};
        // New nibble enters at the top so the LS nibble ends up at bit 0 after NIBBLES steps.
        acc_d      = (acc_q >> 4) | (W'(nib[3:0]) << (W - 4));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            acc_q        <= '0;
            sum_q        <= '0;
            carry_q      <= 1'b0;
            cout_q       <= 1'b0;
            id_q         <= 1'b0;
            cnt_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req0_ready || req1_ready) begin
                        a_q          <= grant ? req1_a : req0_a;
                        b_q          <= grant ? req1_b : req0_b;
                        carry_q      <= 1'b0;
                        cnt_q        <= '0;
                        last_grant_q <= grant;
                        id_q         <= grant;
                        state_q      <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> 4;
                    b_q     <= b_q >> 4;
                    carry_q <= nib[4];
                    cnt_q   <= cnt_q + CW'(1);
                    acc_q   <= acc_d;
                    if (cnt_q == LAST) begin
                        // Published result only changes here, so it holds through IDLE and RUN.
                        sum_q   <= acc_d;
                        cout_q  <= nib[4];
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign res_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign res_sum   = sum_q;
    assign res_cout  = cout_q;
    assign res_id    = id_q;
endmodule
